// File: rtl/cfg_src_pkg.sv
// Shared definitions for the configuration bitstream stream source:
// FSM encoding and byte/keep helpers.
package cfg_src_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Widest stream supported by keep_from_rem; callers narrow the result.
  localparam int MAX_BYTES = 128;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic logic [MAX_BYTES-1:0] keep_from_rem(input int unsigned rem);
    if (rem == 0) begin
      return '1;
    end
    return (MAX_BYTES'(1) << rem) - MAX_BYTES'(1);
  endfunction

endpackage

// File: rtl/cfg_src_fifo.sv
// Small first-word-fall-through FIFO with an occupancy count.
// Head data reads as zero while empty, so the stream bus idles at zero.
module cfg_src_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign do_rd = rd_en && !empty;
  // A write into a full FIFO is fine when the head leaves in the same cycle.
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];
  assign count   = count_reg;

  overflow_check: assert property (@(posedge clk) disable iff (!resetn)
    !(wr_en && full && !do_rd));

endmodule

// File: rtl/cfg_stream_src.sv
// Streams a partial bitstream from a synchronous memory read port onto an
// AXI-stream master with tkeep/tlast, reporting start, completion and errors.
module cfg_stream_src
  import cfg_src_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  output logic                       mem_ren,
  output logic [ADDR_WIDTH-1:0]      mem_raddr,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       config_start,
  output logic                       done,
  output logic                       err,
  output logic                       busy
);

  localparam int BYTES  = bytes_of(DATA_WIDTH);
  localparam int FIFO_W = DATA_WIDTH + BYTES + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_t                 state_reg;
  state_t                 state_next;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [LEN_WIDTH-1:0]   beats_reg;
  logic [LEN_WIDTH-1:0]   issued_reg;
  logic [BYTES-1:0]       last_keep_reg;
  logic                   inflight_reg;
  logic                   inflight_last_reg;
  logic                   config_start_reg;
  logic                   done_reg;
  logic                   err_reg;

  logic [LEN_WIDTH-1:0]   len_rem;
  logic [LEN_WIDTH-1:0]   len_beats;
  logic                   accept;
  logic                   reject;
  logic                   issue;
  logic                   last_issue;
  logic                   fifo_rd;
  logic                   fifo_empty;
  logic                   tlast_hs;
  logic [CNT_W-1:0]       occupancy;
  logic [CNT_W-1:0]       level;
  logic [BYTES-1:0]       wr_keep;
  logic [DATA_WIDTH-1:0]  wr_data_masked;
  logic [FIFO_W-1:0]      fifo_wdata;
  logic [FIFO_W-1:0]      fifo_rdata;

  assign len_rem   = cmd_len % LEN_WIDTH'(BYTES);
  assign len_beats = cmd_len / LEN_WIDTH'(BYTES) + LEN_WIDTH'(len_rem != '0);

  assign accept = (state_reg == IDLE) && cmd_valid && (cmd_len != '0);
  assign reject = (state_reg == IDLE) && cmd_valid && (cmd_len == '0);

  // Words already in the FIFO plus the one returning this cycle bound the issue.
  assign level      = occupancy + CNT_W'(inflight_reg);
  assign issue      = (state_reg == READ) && (issued_reg < beats_reg) &&
                      (level < CNT_W'(FIFO_DEPTH));
  assign last_issue = (issued_reg == beats_reg - LEN_WIDTH'(1));

  assign fifo_rd  = !fifo_empty && m_axis_tready;
  assign tlast_hs = fifo_rd && m_axis_tlast;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      beats_reg         <= '0;
      issued_reg        <= '0;
      last_keep_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      config_start_reg  <= 1'b0;
      done_reg          <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      state_reg         <= state_next;
      config_start_reg  <= accept;
      err_reg           <= reject;
      done_reg          <= (state_reg == DRAIN) && tlast_hs && !done_reg;
      inflight_reg      <= issue;
      inflight_last_reg <= issue && last_issue;
      if (accept) begin
        addr_reg      <= cmd_addr;
        beats_reg     <= len_beats;
        issued_reg    <= '0;
        last_keep_reg <= BYTES'(keep_from_rem(32'(len_rem)));
      end else if (issue) begin
        issued_reg <= issued_reg + LEN_WIDTH'(1);
      end
    end
  end

  // DRAIN lingers through the done cycle so cmd_ready rises only afterwards.
  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    mem_ren    = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept) begin
          state_next = READ;
        end
      end
      READ: begin
        mem_ren = issue;
        if (issue && last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (done_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_raddr = addr_reg + ADDR_WIDTH'(issued_reg);

  assign wr_keep = inflight_last_reg ? last_keep_reg : '1;

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte_mask
      assign wr_data_masked[gi*8 +: 8] = wr_keep[gi] ? mem_rdata[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign fifo_wdata = {inflight_last_reg, wr_keep, wr_data_masked};

  cfg_src_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (inflight_reg),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .count   (occupancy)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_rdata;

  assign config_start = config_start_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_cfg_stream_src.sv
// Directed bench for cfg_stream_src: memory model, per-scenario tasks with
// hand-derived expectations, one summary line at the end.
module tb_cfg_stream_src;

  logic         clk = 1'b0;
  logic         resetn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_addr;
  logic [23:0]  cmd_len;
  logic         mem_ren;
  logic [31:0]  mem_raddr;
  logic [255:0] mem_rdata = '0;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         config_start;
  logic         done;
  logic         err;
  logic         busy;

  int checks;
  int errors;

  logic [255:0] got_data[$];
  logic [31:0]  got_keep[$];
  logic         got_last[$];
  logic [31:0]  got_raddr[$];
  int r_cs, r_err, r_stab, r_ren, r_first_valid, r_last_cyc, r_done_cyc;

  cfg_stream_src dut (
    .clk           (clk),
    .resetn        (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .mem_ren       (mem_ren),
    .mem_raddr     (mem_raddr),
    .mem_rdata     (mem_rdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .config_start  (config_start),
    .done          (done),
    .err           (err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Every byte has bit 7 set, so a zeroed byte is always distinguishable.
  function automatic logic [255:0] mem_word(input logic [31:0] a);
    logic [255:0] w;
    for (int j = 0; j < 32; j++) begin
      w[j*8 +: 8] = {1'b1, 7'(a[6:0] * 7'd3 + 7'(j))};
    end
    return w;
  endfunction

  function automatic logic [255:0] mask_word(input logic [255:0] w, input logic [31:0] k);
    logic [255:0] r;
    for (int j = 0; j < 32; j++) begin
      r[j*8 +: 8] = k[j] ? w[j*8 +: 8] : 8'h00;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_ren) begin
      mem_rdata <= mem_word(mem_raddr);
    end
  end

  function automatic int count_bad_beats(input logic [31:0] base, input int n,
                                         input logic [31:0] last_keep);
    int bad;
    logic [31:0] k;
    bad = (got_data.size() != n) ? 1 : 0;
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      k = (i == n - 1) ? last_keep : 32'hFFFF_FFFF;
      if (got_keep[i] !== k || got_last[i] !== (i == n - 1) ||
          got_data[i] !== mask_word(mem_word(base + 32'(i)), k)) begin
        bad++;
      end
    end
    return bad;
  endfunction

  task automatic send_cmd(input logic [31:0] a, input logic [23:0] l);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Starts on the first cycle after acceptance; returns on the negedge where done is seen.
  task automatic run_stream(input int exp_beats, input bit rand_ready, input int max_cycles);
    int issued, hs;
    logic prev_stall, pl;
    logic [255:0] pd;
    logic [31:0] pk;
    got_data.delete(); got_keep.delete(); got_last.delete(); got_raddr.delete();
    r_cs = 0; r_err = 0; r_stab = 0; r_ren = 0;
    r_first_valid = -1; r_last_cyc = -1; r_done_cyc = -1;
    issued = 0; hs = 0; prev_stall = 1'b0; pd = '0; pk = '0; pl = 1'b0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      r_cs  += int'(config_start);
      r_err += int'(err);
      if (mem_ren !== ((issued < exp_beats) && (issued - hs < 4))) r_ren++;
      if (mem_ren === 1'b1) got_raddr.push_back(mem_raddr);
      if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd ||
                         m_axis_tkeep !== pk || m_axis_tlast !== pl)) r_stab++;
      if (m_axis_tvalid === 1'b1 && r_first_valid < 0) r_first_valid = cyc;
      if (done === 1'b1) begin
        r_done_cyc = cyc;
        break;
      end
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
        got_data.push_back(m_axis_tdata);
        got_keep.push_back(m_axis_tkeep);
        got_last.push_back(m_axis_tlast);
        hs++;
        if (m_axis_tlast === 1'b1) r_last_cyc = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast;
      issued += int'(mem_ren === 1'b1);
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if ({cmd_ready, mem_ren, m_axis_tvalid, m_axis_tlast, config_start, done, err, busy} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 10000000", {cmd_ready, mem_ren, m_axis_tvalid, m_axis_tlast, config_start, done, err, busy});
    end
    checks++;
    if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || mem_raddr !== '0) begin
      errors++;
      $display("FAIL reset_bus: tdata=%h tkeep=%h raddr=%h, required all zero", m_axis_tdata, m_axis_tkeep, mem_raddr);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    $display("reset: outputs sampled in and after reset");
  endtask

  task automatic test_basic();
    int bad;
    send_cmd(32'h100, 24'd64);
    run_stream(2, 1'b0, 50);
    checks++;
    if (got_raddr.size() != 2 || got_raddr[0] !== 32'h100 || got_raddr[1] !== 32'h101) begin
      errors++;
      $display("FAIL basic_raddr: got %0d reads first %h, required 2 reads 100,101", got_raddr.size(), got_raddr.size() > 0 ? got_raddr[0] : 32'hx);
    end
    bad = count_bad_beats(32'h100, 2, 32'hFFFF_FFFF);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_beats: %0d bad of %0d received, required 0 bad of 2", bad, got_data.size());
    end
    checks++;
    if (r_cs != 1) begin
      errors++;
      $display("FAIL basic_config_start: %0d pulses, required 1", r_cs);
    end
    checks++;
    if (r_first_valid != 2 || r_last_cyc != 3) begin
      errors++;
      $display("FAIL basic_latency: first tvalid %0d last %0d, required 2 3", r_first_valid, r_last_cyc);
    end
    checks++;
    if (r_done_cyc != r_last_cyc + 1 || r_done_cyc < 0) begin
      errors++;
      $display("FAIL basic_done: done at %0d, required %0d", r_done_cyc, r_last_cyc + 1);
    end
    checks++;
    if (r_ren != 0) begin
      errors++;
      $display("FAIL basic_ren: %0d cycles wrong, required 0", r_ren);
    end
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_at_done: cmd_ready=%b busy=%b, required 0 1", cmd_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_after_done: cmd_ready=%b busy=%b done=%b, required 1 0 0", cmd_ready, busy, done);
    end
    $display("basic: addr 100 len 64 -> %0d beats", got_data.size());
  endtask

  task automatic test_partial();
    int bad;
    send_cmd(32'h200, 24'd70);
    run_stream(3, 1'b0, 50);
    bad = count_bad_beats(32'h200, 3, 32'h0000_003F);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL partial_beats: %0d bad of %0d received, required 0 bad of 3", bad, got_data.size());
    end
    checks++;
    if (got_data.size() != 3 || got_keep[2] !== 32'h0000_003F || got_data[2][255:48] !== '0) begin
      errors++;
      $display("FAIL partial_last: tkeep=%h upper=%h, required 0000003f and zero", got_keep.size() > 2 ? got_keep[2] : 32'hx, got_data.size() > 2 ? got_data[2][255:48] : 208'hx);
    end
    checks++;
    if (got_raddr.size() != 3 || got_raddr[2] !== 32'h202 || r_done_cyc < 0) begin
      errors++;
      $display("FAIL partial_reads: %0d reads done_cyc %0d, required 3 reads ending 202 and done", got_raddr.size(), r_done_cyc);
    end
    @(negedge clk);
    $display("partial: addr 200 len 70 -> %0d beats", got_data.size());
  endtask

  task automatic test_random_ready();
    int bad;
    send_cmd(32'h300, 24'd4096);
    run_stream(128, 1'b1, 3000);
    bad = count_bad_beats(32'h300, 128, 32'hFFFF_FFFF);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_beats: %0d bad of %0d received, required 0 bad of 128", bad, got_data.size());
    end
    checks++;
    if (r_stab != 0) begin
      errors++;
      $display("FAIL random_stable: %0d stalled cycles changed, required 0", r_stab);
    end
    checks++;
    if (r_ren != 0) begin
      errors++;
      $display("FAIL random_ren: %0d cycles with wrong mem_ren, required 0", r_ren);
    end
    checks++;
    if (got_raddr.size() != 128 || got_raddr[127] !== 32'h37F) begin
      errors++;
      $display("FAIL random_reads: %0d reads, required 128 ending 37f", got_raddr.size());
    end
    checks++;
    if (r_done_cyc < 0 || r_done_cyc != r_last_cyc + 1) begin
      errors++;
      $display("FAIL random_done: done at %0d last at %0d, required last+1", r_done_cyc, r_last_cyc);
    end
    @(negedge clk);
    $display("random_ready: addr 300 len 4096 -> %0d beats", got_data.size());
  endtask

  task automatic test_zero_len();
    int bad;
    send_cmd(32'h800, 24'd0);
    checks++;
    if (err !== 1'b1 || config_start !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || mem_ren !== 1'b0) begin
      errors++;
      $display("FAIL zero_err: err=%b cs=%b ready=%b busy=%b ren=%b, required 1 0 1 0 0", err, config_start, cmd_ready, busy, mem_ren);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (err !== 1'b0 || mem_ren !== 1'b0 || m_axis_tvalid !== 1'b0 ||
          config_start !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL zero_quiet: %0d cycles with activity, required 0", bad);
    end
    $display("zero_len: len 0 rejected");
  endtask

  task automatic test_back_to_back();
    int bad;
    cmd_addr = 32'h400; cmd_len = 24'd96; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_addr = 32'h500; cmd_len = 24'd32;
    run_stream(3, 1'b0, 50);
    bad = count_bad_beats(32'h400, 3, 32'hFFFF_FFFF);
    checks++;
    if (bad != 0 || got_raddr.size() != 3 || got_raddr[2] !== 32'h402) begin
      errors++;
      $display("FAIL b2b_first: %0d bad beats %0d reads, required 0 and 3 ending 402", bad, got_raddr.size());
    end
    checks++;
    if (r_cs != 1 || r_done_cyc < 0) begin
      errors++;
      $display("FAIL b2b_single_start: %0d starts done_cyc %0d, required 1 and done", r_cs, r_done_cyc);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_at_done: cmd_ready=%b, required 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_after_done: cmd_ready=%b, required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (config_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept: config_start=%b, required 1", config_start);
    end
    run_stream(1, 1'b0, 50);
    bad = count_bad_beats(32'h500, 1, 32'hFFFF_FFFF);
    checks++;
    if (bad != 0 || got_raddr.size() != 1 || got_raddr[0] !== 32'h500) begin
      errors++;
      $display("FAIL b2b_second: %0d bad beats %0d reads, required 0 and one read at 500", bad, got_raddr.size());
    end
    @(negedge clk);
    $display("back_to_back: 400/96 then 500/32 -> %0d beats on second", got_data.size());
  endtask

  task automatic test_reset_mid();
    int hs, bad;
    send_cmd(32'h600, 24'd256);
    hs = 0;
    for (int c = 0; c < 40 && hs < 3; c++) begin
      if (m_axis_tvalid === 1'b1) hs++;
      if (hs < 3) @(negedge clk);
    end
    checks++;
    if (hs != 3) begin
      errors++;
      $display("FAIL mid_progress: %0d beats seen, required 3", hs);
    end
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, mem_ren, m_axis_tvalid, m_axis_tlast, config_start, done, err, busy} !== 8'b1000_0000 ||
        m_axis_tdata !== '0 || m_axis_tkeep !== '0) begin
      errors++;
      $display("FAIL mid_async_reset: ctrl=%b tkeep=%h, required 10000000 and zero buses", {cmd_ready, mem_ren, m_axis_tvalid, m_axis_tlast, config_start, done, err, busy}, m_axis_tkeep);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || m_axis_tvalid !== 1'b0) bad++;
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_no_done: %0d cycles with done or tvalid, required 0", bad);
    end
    send_cmd(32'h700, 24'd256);
    run_stream(8, 1'b0, 60);
    bad = count_bad_beats(32'h700, 8, 32'hFFFF_FFFF);
    checks++;
    if (bad != 0 || got_raddr.size() != 8 || got_raddr[0] !== 32'h700) begin
      errors++;
      $display("FAIL mid_restart: %0d bad beats %0d reads, required 0 and 8 from 700", bad, got_raddr.size());
    end
    checks++;
    if (r_first_valid != 2 || r_done_cyc < 0) begin
      errors++;
      $display("FAIL mid_restart_timing: first tvalid %0d done_cyc %0d, required 2 and done", r_first_valid, r_done_cyc);
    end
    @(negedge clk);
    $display("reset_mid: aborted 600/256, then 700/256 -> %0d beats", got_data.size());
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_partial();
    test_random_ready();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
